// File: rtl/thor2023_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : thor2023_icache_miss_ctrl
// Purpose  : 4-way I-cache tag lookup, hit detect, victim select, line refill
// Revision : 1.0
// ============================================================================
module thor2023_icache_miss_ctrl #(
    parameter  int LINES  = 256,
    parameter  int WAYS   = 4,
    parameter  int TAGBIT = 14,
    parameter  int LOBIT  = 6,
    parameter  int ADRW   = 32,
    parameter  int BEATS  = 4,
    localparam int IDXW   = $clog2(LINES),
    localparam int BEATW  = $clog2(BEATS),
    localparam int TAGW   = ADRW - TAGBIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_vld,
    input  logic [ADRW-1:0]        req_adr,
    output logic                   req_rdy,
    output logic                   hit,
    output logic [1:0]             hit_way,
    input  logic                   inv,
    output logic [IDXW-1:0]        ndx_o,
    input  logic [WAYS*TAGW-1:0]   tag_i,
    output logic                   tag_wr,
    output logic [1:0]             tag_way,
    output logic [ADRW-1:0]        tag_adr,
    output logic                   mem_req,
    output logic [ADRW-1:0]        mem_adr,
    input  logic                   mem_ack,
    output logic                   line_wr,
    output logic [1:0]             line_way,
    output logic [BEATW-1:0]       line_beat
);

    localparam int HIBIT = LOBIT + IDXW - 1;
    localparam int BOFS  = LOBIT - BEATW;
    localparam logic [ADRW-1:0] LINE_MASK = ADRW'((1 << LOBIT) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TAGWR = 2'd2
    } state_t;

    state_t          state;
    logic [WAYS-1:0] valid [LINES];
    logic [ADRW-1:0] line_adr;
    logic [1:0]      victim;
    logic [1:0]      rr;
    logic [BEATW-1:0] beat;
    logic [BEATW-1:0] beat_nxt;
    logic [WAYS-1:0] match;
    logic [TAGW-1:0] req_tag;

    assign req_tag  = req_adr[ADRW-1:TAGBIT];
    assign beat_nxt = beat + 1'b1;

    // Outside IDLE the tag RAM must keep pointing at the set being refilled.
    assign ndx_o = (state == IDLE) ? req_adr[HIBIT:LOBIT] : line_adr[HIBIT:LOBIT];

    always_comb begin
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid[ndx_o][w] && (tag_i[w*TAGW +: TAGW] == req_tag);
        end
    end

    // Scan downwards so the lowest matching way is the one left standing.
    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way = 2'(w);
            end
        end
    end

    assign hit       = (state == IDLE) && req_vld && (|match);
    assign line_wr   = (state == FETCH) && mem_req && mem_ack;
    assign line_way  = victim;
    assign line_beat = beat;
    assign tag_way   = victim;
    assign tag_adr   = line_adr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_rdy  <= 1'b1;
            mem_req  <= 1'b0;
            mem_adr  <= '0;
            tag_wr   <= 1'b0;
            line_adr <= '0;
            victim   <= '0;
            rr       <= '0;
            beat     <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid[i] <= '0;
            end
        end else begin
            tag_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_vld && !hit) begin
                        line_adr <= req_adr & ~LINE_MASK;
                        victim   <= rr;
                        req_rdy  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // First FETCH cycle only launches the request for the current beat.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_adr <= line_adr + (ADRW'(beat) << BOFS);
                    end else if (mem_ack) begin
                        beat <= beat_nxt;
                        if (beat == BEATW'(BEATS - 1)) begin
                            mem_req <= 1'b0;
                            tag_wr  <= 1'b1;
                            state   <= TAGWR;
                        end else begin
                            mem_adr <= line_adr + (ADRW'(beat_nxt) << BOFS);
                        end
                    end
                end
                TAGWR: begin
                    rr      <= rr + 1'b1;
                    beat    <= '0;
                    req_rdy <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    req_rdy <= 1'b1;
                    state   <= IDLE;
                end
            endcase

            // An invalidate landing on the tag write wins, so the new line stays invalid.
            if (inv) begin
                for (int i = 0; i < LINES; i++) begin
                    valid[i] <= '0;
                end
            end else if (state == TAGWR) begin
                valid[line_adr[HIBIT:LOBIT]][victim] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_thor2023_icache_miss_ctrl.sv
`default_nettype none
// Bench for thor2023_icache_miss_ctrl: refill beats and tag writes are predicted
// when a miss is issued and retired in order as the controller produces them.
module tb_thor2023_icache_miss_ctrl;

    localparam int TAGW = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_vld = 1'b0;
    logic [31:0]       req_adr = '0;
    logic              req_rdy;
    logic              hit;
    logic [1:0]        hit_way;
    logic              inv;
    logic [7:0]        ndx_o;
    logic [4*TAGW-1:0] tag_i;
    logic              tag_wr;
    logic [1:0]        tag_way;
    logic [31:0]       tag_adr;
    logic              mem_req;
    logic [31:0]       mem_adr;
    logic              mem_ack;
    logic              line_wr;
    logic [1:0]        line_way;
    logic [1:0]        line_beat;

    thor2023_icache_miss_ctrl dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_adr(req_adr), .req_rdy(req_rdy),
        .hit(hit), .hit_way(hit_way), .inv(inv), .ndx_o(ndx_o), .tag_i(tag_i),
        .tag_wr(tag_wr), .tag_way(tag_way), .tag_adr(tag_adr), .mem_req(mem_req),
        .mem_adr(mem_adr), .mem_ack(mem_ack), .line_wr(line_wr), .line_way(line_way),
        .line_beat(line_beat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [1:0]  beat;
        logic [1:0]  way;
    } beat_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [1:0]  way;
    } tagw_t;

    beat_t beat_q[$];
    tagw_t tag_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    logic [1:0] tb_rr = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Tag RAM model: written by the controller, occasionally poked by the bench.
    logic [TAGW-1:0] tram [256][4];
    logic            tram_ready = 1'b0;
    logic            poke_en = 1'b0;
    logic [1:0]      poke_way = '0;
    logic [TAGW-1:0] poke_val = '0;

    always @(posedge clk) begin
        if (!tram_ready) begin
            for (int i = 0; i < 256; i++)
                for (int w = 0; w < 4; w++) tram[i][w] <= '0;
            tram_ready <= 1'b1;
        end else begin
            if (tag_wr) tram[ndx_o][tag_way] <= tag_adr[31:14];
            if (poke_en) tram[1][poke_way] <= poke_val;
        end
    end

    always_comb begin
        tag_i = '0;
        for (int w = 0; w < 4; w++) tag_i[w*TAGW +: TAGW] = tram[ndx_o][w];
    end

    // Scoreboard retirement of beats and tag writes.
    always @(negedge clk) begin
        beat_t eb;
        tagw_t et;
        if (rst && line_wr) begin
            check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
            if (beat_q.size() != 0) begin
                eb = beat_q.pop_front();
                check("mem_adr", mem_adr, eb.adr);
                check("line_beat", 32'(line_beat), 32'(eb.beat));
                check("line_way", 32'(line_way), 32'(eb.way));
            end
        end
        if (rst && tag_wr) begin
            check("tagwr_expected", 32'(tag_q.size() != 0), 32'd1);
            if (tag_q.size() != 0) begin
                et = tag_q.pop_front();
                check("tag_adr", tag_adr, et.adr);
                check("tag_way", 32'(tag_way), 32'(et.way));
            end
        end
    end

    // Memory responder and invalidate injector, driven just after each rising edge.
    int   stall_len = 0;
    logic [31:0] stall_adr = '0;
    logic inv_fetch_arm = 1'b0;
    logic inv_tagwr_arm = 1'b0;

    initial begin
        int held;
        held    = 0;
        mem_ack = 1'b0;
        inv     = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            inv = (inv_tagwr_arm && tag_wr) || (inv_fetch_arm && mem_req && line_beat == 2'd1);
            if (stall_len == 0) held = 0;
            if (stall_len > 0 && line_beat == 2'd2 && held < stall_len) begin
                held++;
                mem_ack = 1'b0;
                check("stall_mem_req", 32'(mem_req), 32'd1);
                check("stall_mem_adr", mem_adr, stall_adr);
            end else begin
                mem_ack = mem_req;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        req_vld = 1'b0;
        beat_q.delete();
        tag_q.delete();
        tb_rr = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_miss(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFC0;
        for (int b = 0; b < 4; b++)
            beat_q.push_back('{adr: base + 32'(b) * 32'd16, beat: 2'(b), way: tb_rr});
        tag_q.push_back('{adr: base, way: tb_rr});
        tb_rr = tb_rr + 2'd1;
    endtask

    task automatic lookup(input logic [31:0] a, input logic exp_hit,
                          input logic [1:0] exp_way, input int exp_lat);
        int lat;
        @(posedge clk);
        #2;
        req_vld = 1'b1;
        req_adr = a;
        @(negedge clk);
        check("lk_req_rdy", 32'(req_rdy), 32'd1);
        check("lk_hit", 32'(hit), 32'(exp_hit));
        if (exp_hit) check("lk_hit_way", 32'(hit_way), 32'(exp_way));
        else push_miss(a);
        @(posedge clk);
        #2;
        req_vld = 1'b0;
        lat = 0;
        @(negedge clk);
        if (exp_hit) check("hit_no_mem_req", 32'(mem_req), 32'd0);
        while (!req_rdy && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check(exp_hit ? "hit_busy_cycles" : "miss_busy_cycles", 32'(lat), 32'(exp_lat));
        check("sb_beats_drained", 32'(beat_q.size()), 32'd0);
        check("sb_tags_drained", 32'(tag_q.size()), 32'd0);
    endtask

    task automatic poke(input logic [1:0] w, input logic [TAGW-1:0] v);
        @(posedge clk);
        #2;
        poke_en  = 1'b1;
        poke_way = w;
        poke_val = v;
        @(posedge clk);
        #2;
        poke_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] v;
        int n;

        // Reset values, checked both in and just after reset.
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_tag_wr", 32'(tag_wr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_line_wr", 32'(line_wr), 32'd0);
        check("rst_mem_adr", mem_adr, 32'd0);
        check("rst_tag_adr", tag_adr, 32'd0);
        check("rst_tag_way", 32'(tag_way), 32'd0);
        check("rst_line_way", 32'(line_way), 32'd0);
        check("rst_line_beat", 32'(line_beat), 32'd0);

        // First miss, then the same line hits in way 0.
        lookup(32'h0000_1040, 1'b0, 2'd0, 6);
        lookup(32'h0000_1040, 1'b1, 2'd0, 0);

        // Five distinct tags in set 1 walk the victim counter 0,1,2,3,0.
        do_reset();
        for (int i = 1; i <= 5; i++) lookup((32'(i) << 14) | 32'h40, 1'b0, 2'd0, 6);
        lookup(32'h0000_8040, 1'b1, 2'd1, 0);
        lookup(32'h0001_4040, 1'b1, 2'd0, 0);
        lookup(32'h0001_0040, 1'b1, 2'd3, 0);
        poke(2'd3, 18'd3);
        lookup(32'h0000_C040, 1'b1, 2'd2, 0);
        poke(2'd1, 18'd4);
        lookup(32'h0001_0040, 1'b1, 2'd1, 0);

        // Ack withheld five cycles on beat 2.
        do_reset();
        stall_adr = 32'h0000_1060;
        stall_len = 5;
        lookup(32'h0000_1040, 1'b0, 2'd0, 11);
        stall_len = 0;

        // Invalidate mid-refill keeps the line; invalidate on the tag write drops it.
        v = tb_rr;
        inv_fetch_arm = 1'b1;
        lookup(32'h0000_3000, 1'b0, 2'd0, 6);
        inv_fetch_arm = 1'b0;
        lookup(32'h0000_3000, 1'b1, v, 0);
        inv_tagwr_arm = 1'b1;
        lookup(32'h0000_2000, 1'b0, 2'd0, 6);
        inv_tagwr_arm = 1'b0;
        v = tb_rr;
        lookup(32'h0000_2000, 1'b0, 2'd0, 6);
        lookup(32'h0000_2000, 1'b1, v, 0);

        // Reset in the middle of a refill.
        do_reset();
        @(posedge clk);
        #2;
        req_vld = 1'b1;
        req_adr = 32'h0000_5040;
        @(negedge clk);
        check("rf_hit", 32'(hit), 32'd0);
        push_miss(32'h0000_5040);
        @(posedge clk);
        #2;
        req_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(line_wr && line_beat == 2'd1) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("rf_beat1_seen", 32'(n < 50), 32'd1);
        @(posedge clk);
        #2;
        check("rf_pre_rst_mem_req", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rf_rst_mem_req", 32'(mem_req), 32'd0);
        check("rf_rst_tag_wr", 32'(tag_wr), 32'd0);
        check("rf_rst_req_rdy", 32'(req_rdy), 32'd1);
        beat_q.delete();
        tag_q.delete();
        tb_rr = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        lookup(32'h0000_5040, 1'b0, 2'd0, 6);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
